alu_seq: RTL and testbench

Parametrised, handshaked successor to the 32-bit combinational ALU: it keeps the `a`/`b`/`control` → `dout`/`cout` contract and adds:
- a registered result with valid/ready flow control;
- zero and signed-overflow flags;
- an iterative multi-cycle multiply.

It sits between the issue stage and writeback, and accepts one operation at a time.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode constants and FSM state encoding.
package alu_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] ALU_ADD = 3'd0;
    localparam logic [OPW-1:0] ALU_SUB = 3'd1;
    localparam logic [OPW-1:0] ALU_AND = 3'd2;
    localparam logic [OPW-1:0] ALU_OR  = 3'd3;
    localparam logic [OPW-1:0] ALU_XOR = 3'd4;
    localparam logic [OPW-1:0] ALU_SLT = 3'd5;
    localparam logic [OPW-1:0] ALU_SLL = 3'd6;
    localparam logic [OPW-1:0] ALU_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst    : clock, synchronous active-high reset
//   start       : latch a/b and begin a WIDTH-step multiply
//   a, b        : operands (sampled on start)
//   done        : current cycle performs the final step
//   prod_lo     : low WIDTH bits of the product after this cycle's step
//   prod_hi_nz  : upper WIDTH bits of that product are nonzero
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH:0]       psum;

    // Multiplier bits live in the low half and are consumed LSB-first; the
    // partial sum enters the high half and everything shifts right once.
    always_comb begin
        psum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {psum, acc_q[WIDTH-1:1]};
    end

    // The product is presented from acc_d so the top can register it on the
    // same edge that retires the last step.
    assign done       = (cnt_q == CW'(1));
    assign prod_lo    = acc_d[WIDTH-1:0];
    assign prod_hi_nz = |acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (start) begin
            cnt_q   <= CW'(WIDTH);
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
        end else if (cnt_q != '0) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and an iterative multiply.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operation handshake (in_ready depends only on state and out_ready)
//   a, b, control     : operands and opcode, sampled at the accepting edge
//   out_valid/out_ready : result handshake
//   dout, cout, zero, ovf : registered result and flags, stable while out_valid
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned W1  = WIDTH + 1;
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic             accept;
    logic             is_mul;
    logic             load_op;
    logic             load_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [W1-1:0]    add_sum;
    logic [W1-1:0]    sub_sum;
    logic [W1-1:0]    shext;
    logic [SHW-1:0]   sh;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (accept && is_mul),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake; DONE may hand over to a new op on the same edge.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        is_mul   = (control == ALU_MUL);
        load_op  = 1'b0;
        load_mul = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = is_mul ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    load_mul = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = accept ? (is_mul ? ST_BUSY : ST_DONE) : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        load_op = accept && !is_mul;
    end

    assign sh = b[SHW-1:0];

    // Single-cycle datapath for every opcode except MUL.
    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + W1'(1);
        // Extra top bit catches the last bit shifted out; stays 0 for sh == 0.
        shext   = {1'b0, a} << sh;
        case (control)
            ALU_ADD: begin
                res   = add_sum[WIDTH-1:0];
                res_c = add_sum[WIDTH];
                res_v = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                res   = sub_sum[WIDTH-1:0];
                res_c = sub_sum[WIDTH];
                res_v = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
            end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLT: res = WIDTH'($signed(a) < $signed(b));
            ALU_SLL: begin
                res   = shext[WIDTH-1:0];
                res_c = shext[WIDTH];
            end
            default: ;
        endcase
    end

    // Result and flag registers; held untouched while the result waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            cout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (load_op) begin
            dout <= res;
            cout <= res_c;
            zero <= (res == '0);
            ovf  <= res_v;
        end else if (load_mul) begin
            dout <= mul_lo;
            cout <= mul_hi_nz;
            zero <= (mul_lo == '0);
            ovf  <= 1'b0;
        end
    end

    assign out_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             cout;
    logic             zero;
    logic             ovf;

    int tests;
    int fails;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one operation for a single accepting edge, then withdraw it.
    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        in_valid = 1'b1;
        control  = op;
        a        = va;
        b        = vb;
        tick();
        in_valid = 1'b0;
        a        = '1;
        b        = '1;
        control  = 3'd0;
    endtask

    initial begin
        clk       = 1'b0;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        control   = 3'd0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dout",      64'(dout),      64'd0);
        chk("rst_flags",     64'({cout, zero, ovf}), 64'd0);

        // ADD wrapping to zero
        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_dout",  64'(dout), 64'h0);
        chk("add_flags", 64'({cout, zero, ovf}), 64'b110);

        // SUB with signed overflow
        issue(3'd1, 32'h8000_0000, 32'h0000_0001);
        chk("sub_dout",  64'(dout), 64'h7FFF_FFFF);
        chk("sub_flags", 64'({cout, zero, ovf}), 64'b101);

        // SLT signed
        issue(3'd5, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("slt_dout", 64'(dout), 64'h1);
        chk("slt_cout", 64'(cout), 64'd0);

        // SLL by 1 and by 32 (shift field wraps to 0)
        issue(3'd6, 32'h8000_0001, 32'h0000_0001);
        chk("sll1_dout", 64'(dout), 64'h2);
        chk("sll1_cout", 64'(cout), 64'd1);
        issue(3'd6, 32'h8000_0001, 32'h0000_0020);
        chk("sll32_dout", 64'(dout), 64'h8000_0001);
        chk("sll32_cout", 64'(cout), 64'd0);

        // AND / OR quick patterns
        issue(3'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("and_dout", 64'(dout), 64'h00F0_1200);
        issue(3'd3, 32'hF000_0000, 32'h0000_000F);
        chk("or_dout", 64'(dout), 64'hF000_000F);

        // MUL 7*6 with output held back to observe in_ready through t+33
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        issue(3'd7, 32'd7, 32'd6);
        out_ready = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("mul_busy_c%0d", i), 64'({out_valid, in_ready}), 64'b00);
            tick();
        end
        chk("mul_valid_t33",   64'(out_valid), 64'd1);
        chk("mul_inready_t33", 64'(in_ready),  64'd0);
        chk("mul_dout",        64'(dout),      64'h2A);
        chk("mul_flags",       64'({cout, zero, ovf}), 64'b000);

        // MUL whose product is exactly 2^32
        out_ready = 1'b1;
        issue(3'd7, 32'h0001_0000, 32'h0001_0000);
        for (int i = 1; i <= 32; i++) tick();
        chk("mul2_valid", 64'(out_valid), 64'd1);
        chk("mul2_dout",  64'(dout), 64'h0);
        chk("mul2_flags", 64'({cout, zero, ovf}), 64'b110);

        // Backpressure on ADD 3+4
        tick();
        out_ready = 1'b0;
        issue(3'd0, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_dout_c%0d", i), 64'(dout), 64'h7);
            chk($sformatf("bp_hs_c%0d", i), 64'({out_valid, in_ready}), 64'b10);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        control   = 3'd4;
        a         = 32'h0000_00F0;
        b         = 32'h0000_000F;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_dout",  64'(dout), 64'hFF);
        tick();
        chk("drain_idle", 64'({out_valid, in_ready}), 64'b01);

        // Reset in the 10th BUSY cycle
        issue(3'd7, 32'd5, 32'd5);
        for (int i = 1; i < 10; i++) tick();
        chk("abort_busy", 64'({out_valid, in_ready}), 64'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_hs",    64'({out_valid, in_ready}), 64'b01);
        chk("abort_dout",  64'(dout), 64'h0);
        chk("abort_flags", 64'({cout, zero, ovf}), 64'b000);

        // Fresh ADD after abort; no late MUL completion afterwards
        issue(3'd0, 32'd1, 32'd1);
        chk("post_valid", 64'(out_valid), 64'd1);
        chk("post_dout",  64'(dout), 64'h2);
        chk("post_flags", 64'({cout, zero, ovf}), 64'b000);
        for (int i = 0; i < 30; i++) tick();
        chk("post_quiet", 64'({out_valid, in_ready}), 64'b01);
        chk("post_hold",  64'(dout), 64'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
